// File: rtl/frame_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// frame_seq_pkg
// Shared definitions for the frame_sequencer block:
//   - state_t / STATE_W : frame-loop FSM state encoding
//   - RECOVER_CYC       : cycles a stage's soft reset is held low after finish
//   - idx_width()       : width of a stage index (at least 1 bit)
// -----------------------------------------------------------------------------
package frame_seq_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE    = 3'd0,
    S_ACK     = 3'd1,
    S_NEXT    = 3'd2,
    S_LAUNCH  = 3'd3,
    S_WAIT    = 3'd4,
    S_RECOVER = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  localparam int RECOVER_CYC = 2;

  // Width of an index into n items; a single item still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/frame_sequencer_if.sv
// -----------------------------------------------------------------------------
// frame_sequencer_if
// Stage-side bus between the frame sequencer and the processing stage cores.
//   stage_start  : one-hot start spike, one cycle per launch
//   stage_finish : per-stage interrupt level from the stage cores
//   stage_rstn   : per-stage active-low soft reset
// Modports: master = sequencer, slave = stage cores.
// -----------------------------------------------------------------------------
interface frame_sequencer_if #(
  parameter int NUM_STAGES = 4
);

  logic [NUM_STAGES-1:0] stage_start;
  logic [NUM_STAGES-1:0] stage_finish;
  logic [NUM_STAGES-1:0] stage_rstn;

  modport master (
    output stage_start,
    output stage_rstn,
    input  stage_finish
  );

  modport slave (
    input  stage_start,
    input  stage_rstn,
    output stage_finish
  );

endinterface

// File: rtl/frame_sequencer_next_stage_sel.sv
// -----------------------------------------------------------------------------
// next_stage_sel
// Combinational priority selector: finds the lowest non-bypassed stage whose
// index is above the current pointer. When ptr_valid is 0 the pointer means
// "before stage 0", so every non-bypassed stage qualifies.
// Ports:
//   bypass     in  NUM_STAGES  1 = skip stage
//   ptr        in  IDX_W       index of the stage that last ran
//   ptr_valid  in  1           0 = pointer sits before stage 0
//   next_idx   out IDX_W       selected stage (0 when none)
//   next_valid out 1           a stage was found
// -----------------------------------------------------------------------------
module next_stage_sel
  import frame_seq_pkg::*;
#(
  parameter  int NUM_STAGES = 4,
  localparam int IDX_W      = idx_width(NUM_STAGES)
) (
  input  logic [NUM_STAGES-1:0] bypass,
  input  logic [IDX_W-1:0]      ptr,
  input  logic                  ptr_valid,
  output logic [IDX_W-1:0]      next_idx,
  output logic                  next_valid
);

  always_comb begin
    // NOTE: outputs get defaults before the search so every path assigns them
    // and no latch is inferred.
    next_idx   = '0;
    next_valid = 1'b0;
    // Scan downwards so the lowest qualifying index is the last one written.
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      if (!bypass[i] && (!ptr_valid || (i > int'(ptr)))) begin
        next_idx   = IDX_W'(i);
        next_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/frame_sequencer.sv
// -----------------------------------------------------------------------------
// frame_sequencer
// Frame-loop controller for the audio compression pipeline. For each of
// num_frames consecutive frames it walks the non-bypassed stages in index
// order: start spike, wait for that stage's finish, then a RECOVER_CYC-cycle
// soft reset of the stage. frame_addr steps by FRAME_STRIDE after each frame.
//
// Optional feature (compile-time macro STAGE_TIMEOUT_EN):
//   defined   : a watchdog counts WAIT cycles; after TIMEOUT_CYC cycles with no
//               finish, err_timeout is set, the active stage is recovered and
//               the run ends in DONE with the remaining work abandoned.
//   undefined : err_timeout is constant 0 and WAIT waits indefinitely.
//
// Ports:
//   clk_in            in   system clock
//   rst_n             in   asynchronous active-low reset
//   start_sys         in   start level, sampled only in IDLE
//   intr_clr_sys      in   interrupt clear, acted on only in DONE
//   start_music_addr  in   base address of frame 0
//   num_frames        in   frames to process (latched at start)
//   stage_bypass      in   per-stage skip mask (latched at start)
//   start_clr_sys     out  one-cycle start acknowledge
//   intr_sys          out  completion interrupt level
//   busy              out  high from ACK through the last NEXT
//   frame_addr        out  base address of the current frame
//   frames_done       out  completed frame count
//   err_timeout       out  sticky watchdog error
//   stage_bus         master modport: stage_start / stage_finish / stage_rstn
// -----------------------------------------------------------------------------
module frame_sequencer
  import frame_seq_pkg::*;
#(
  parameter int NUM_STAGES   = 4,
  parameter int ADDR_W       = 19,
  parameter int FRAME_STRIDE = 256,
  parameter int CNT_W        = 16,
  parameter int TIMEOUT_CYC  = 65536
) (
  input  logic                   clk_in,
  input  logic                   rst_n,
  input  logic                   start_sys,
  input  logic                   intr_clr_sys,
  input  logic [ADDR_W-1:0]      start_music_addr,
  input  logic [CNT_W-1:0]       num_frames,
  input  logic [NUM_STAGES-1:0]  stage_bypass,
  output logic                   start_clr_sys,
  output logic                   intr_sys,
  output logic                   busy,
  output logic [ADDR_W-1:0]      frame_addr,
  output logic [CNT_W-1:0]       frames_done,
  output logic                   err_timeout,
  frame_sequencer_if.master      stage_bus
);

  localparam int IDX_W = idx_width(NUM_STAGES);
  localparam int REC_W = idx_width(RECOVER_CYC);

  state_t                state;
  logic [CNT_W-1:0]      nf_q;
  logic [NUM_STAGES-1:0] bypass_q;
  logic [NUM_STAGES-1:0] start_q;
  logic [NUM_STAGES-1:0] rstn_q;
  logic [IDX_W-1:0]      ptr;
  logic                  ptr_valid;
  logic                  frame_end;
  logic [REC_W-1:0]      rec_cnt;
  logic [IDX_W-1:0]      sel_idx;
  logic                  sel_valid;
  logic [CNT_W-1:0]      frames_done_inc;

  assign frames_done_inc       = frames_done + CNT_W'(1);
  assign stage_bus.stage_start = start_q;
  assign stage_bus.stage_rstn  = rstn_q;

`ifdef STAGE_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wd_cnt;
  logic            abort_q;
  logic            err_q;
  assign err_timeout = err_q;
`else
  // Watchdog not built: constant 0 for any legal TIMEOUT_CYC.
  assign err_timeout = (TIMEOUT_CYC < 0);
`endif

  next_stage_sel #(
    .NUM_STAGES (NUM_STAGES)
  ) u_sel (
    .bypass     (bypass_q),
    .ptr        (ptr),
    .ptr_valid  (ptr_valid),
    .next_idx   (sel_idx),
    .next_valid (sel_valid)
  );

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      start_clr_sys <= 1'b0;
      intr_sys      <= 1'b0;
      busy          <= 1'b0;
      frame_addr    <= '0;
      frames_done   <= '0;
      nf_q          <= '0;
      bypass_q      <= '0;
      start_q       <= '0;
      rstn_q        <= '0;
      ptr           <= '0;
      ptr_valid     <= 1'b0;
      frame_end     <= 1'b0;
      rec_cnt       <= '0;
`ifdef STAGE_TIMEOUT_EN
      wd_cnt        <= '0;
      abort_q       <= 1'b0;
      err_q         <= 1'b0;
`endif
    end else begin
      // NOTE: state registers use non-blocking assignments so every decision
      // below sees the values from before this edge.
      start_clr_sys <= 1'b0;
      start_q       <= '0;

      case (state)
        S_IDLE: begin
          // Also releases the stage resets on the first edge after rst_n.
          rstn_q <= '1;
          if (start_sys) begin
            state         <= S_ACK;
            start_clr_sys <= 1'b1;
            busy          <= 1'b1;
            frame_addr    <= start_music_addr;
            nf_q          <= num_frames;
            bypass_q      <= stage_bypass;
            frames_done   <= '0;
          end
        end

        S_ACK: begin
          ptr_valid <= 1'b0;
          frame_end <= 1'b0;
          if (nf_q == '0) begin
            state    <= S_DONE;
            busy     <= 1'b0;
            intr_sys <= 1'b1;
          end else begin
            state <= S_NEXT;
          end
        end

        // NEXT runs in two flavours: a search cycle that launches the next
        // stage or flags the frame as finished, and a frame-end cycle that
        // books the frame and rewinds the pointer for the next one.
        S_NEXT: begin
          if (frame_end) begin
            frame_end   <= 1'b0;
            ptr_valid   <= 1'b0;
            frames_done <= frames_done_inc;
            frame_addr  <= frame_addr + ADDR_W'(FRAME_STRIDE);
            if (frames_done_inc == nf_q) begin
              state    <= S_DONE;
              busy     <= 1'b0;
              intr_sys <= 1'b1;
            end
          end else if (sel_valid) begin
            ptr              <= sel_idx;
            ptr_valid        <= 1'b1;
            start_q[sel_idx] <= 1'b1;
            state            <= S_LAUNCH;
          end else begin
            frame_end <= 1'b1;
          end
        end

        S_LAUNCH: begin
          state <= S_WAIT;
`ifdef STAGE_TIMEOUT_EN
          wd_cnt <= '0;
`endif
        end

        S_WAIT: begin
          // Only the active stage's finish matters; a level already high on
          // entry is taken on the first WAIT edge.
          if (stage_bus.stage_finish[ptr]) begin
            state       <= S_RECOVER;
            rstn_q[ptr] <= 1'b0;
            rec_cnt     <= '0;
          end
`ifdef STAGE_TIMEOUT_EN
          else if (wd_cnt == WD_W'(TIMEOUT_CYC - 1)) begin
            state       <= S_RECOVER;
            rstn_q[ptr] <= 1'b0;
            rec_cnt     <= '0;
            err_q       <= 1'b1;
            abort_q     <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
          end
`endif
        end

        S_RECOVER: begin
          if (rec_cnt == REC_W'(RECOVER_CYC - 1)) begin
            rstn_q <= '1;
`ifdef STAGE_TIMEOUT_EN
            if (abort_q) begin
              state    <= S_DONE;
              busy     <= 1'b0;
              intr_sys <= 1'b1;
            end else
`endif
            state <= S_NEXT;
          end else begin
            rec_cnt <= rec_cnt + REC_W'(1);
          end
        end

        S_DONE: begin
          // A clear wins over a simultaneous start; start is re-sampled in IDLE.
          if (intr_clr_sys) begin
            state    <= S_IDLE;
            intr_sys <= 1'b0;
`ifdef STAGE_TIMEOUT_EN
            err_q    <= 1'b0;
            abort_q  <= 1'b0;
`endif
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
